// File: rtl/jbr_gen.sv
// Branch resolution: evaluates branches/jumps, drives the registered {taken, target} fetch redirect bus, squashes wrong path.
// Latency: accept edge N -> bus and output valid in cycle N+1; bus drops the cycle after fetch accepts the redirect.
// Backpressure: allow_in = ~over | next_allow_in; a downstream stall throttles accepts only, never the redirect FSM.
module jbr_gen #(
    parameter int RegW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ctl_br_valid_i,
    output logic            ctl_br_allow_in_o,
    input  logic [RegW-1:0] br_pc_i,
    input  logic [3:0]      br_op_i,
    input  logic [RegW-1:0] br_src1_i,
    input  logic [RegW-1:0] br_src2_i,
    input  logic [RegW-1:0] br_offs_i,
    input  logic            ctl_next_allow_in_i,
    output logic            ctl_br_over_o,
    output logic            br_link_we_o,
    output logic [RegW-1:0] br_link_o,
    input  logic            ctl_if_allow_in_i,
    output logic [RegW:0]   jbr_bus_o
);

    localparam logic [3:0] OpBeq  = 4'd1;
    localparam logic [3:0] OpBne  = 4'd2;
    localparam logic [3:0] OpBlt  = 4'd3;
    localparam logic [3:0] OpBge  = 4'd4;
    localparam logic [3:0] OpBltu = 4'd5;
    localparam logic [3:0] OpBgeu = 4'd6;
    localparam logic [3:0] OpB    = 4'd7;
    localparam logic [3:0] OpBl   = 4'd8;
    localparam logic [3:0] OpJirl = 4'd9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RegW-1:0] tgt_q, tgt_d;
    logic [RegW:0]   bus_q, bus_d;
    logic            over_q;
    logic            link_we_q;
    logic [RegW-1:0] link_q;

    logic            accept;
    logic            load;
    logic            taken;
    logic            is_link;
    logic [RegW-1:0] target;
    logic            eq;
    logic            lt_s;
    logic            lt_u;

    assign ctl_br_allow_in_o = ~over_q | ctl_next_allow_in_i;
    assign accept            = ctl_br_valid_i & ctl_br_allow_in_o;

    assign eq      = (br_src1_i == br_src2_i);
    assign lt_s    = ($signed(br_src1_i) < $signed(br_src2_i));
    assign lt_u    = (br_src1_i < br_src2_i);
    assign is_link = (br_op_i == OpBl) || (br_op_i == OpJirl);
    assign target  = ((br_op_i == OpJirl) ? br_src1_i : br_pc_i) + br_offs_i;

    always_comb begin
        taken = 1'b0;
        case (br_op_i)
            OpBeq:              taken = eq;
            OpBne:              taken = ~eq;
            OpBlt:              taken = lt_s;
            OpBge:              taken = ~lt_s;
            OpBltu:             taken = lt_u;
            OpBgeu:             taken = ~lt_u;
            OpB, OpBl, OpJirl:  taken = 1'b1;
            default:            taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        bus_d   = bus_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (taken) begin
                        state_d = REDIRECT;
                        tgt_d   = target;
                        bus_d   = {1'b1, target};
                    end
                end
            end
            REDIRECT: begin
                // anything accepted here is wrong path and is silently dropped
                if (ctl_if_allow_in_i) begin
                    state_d = SQUASH;
                    bus_d   = '0;
                end
            end
            SQUASH: begin
                if (accept && (br_pc_i == tgt_q)) begin
                    load = 1'b1;
                    if (taken) begin
                        state_d = REDIRECT;
                        tgt_d   = target;
                        bus_d   = {1'b1, target};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bus_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            bus_q     <= '0;
            over_q    <= 1'b0;
            link_we_q <= 1'b0;
            link_q    <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            bus_q   <= bus_d;
            if (load) begin
                over_q    <= 1'b1;
                link_we_q <= is_link;
                link_q    <= br_pc_i + RegW'(4);
            end else if (ctl_next_allow_in_i) begin
                over_q    <= 1'b0;
                link_we_q <= 1'b0;
            end
        end
    end

    assign ctl_br_over_o = over_q;
    assign br_link_we_o  = link_we_q;
    assign br_link_o     = link_q;
    assign jbr_bus_o     = bus_q;

endmodule

// File: tb/tb_jbr_gen.sv
// Directed bench for jbr_gen: redirect bus timing, compare flavours, squash and reset behaviour.
module tb_jbr_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ctl_br_valid_i;
    logic        ctl_br_allow_in_o;
    logic [31:0] br_pc_i;
    logic [3:0]  br_op_i;
    logic [31:0] br_src1_i;
    logic [31:0] br_src2_i;
    logic [31:0] br_offs_i;
    logic        ctl_next_allow_in_i;
    logic        ctl_br_over_o;
    logic        br_link_we_o;
    logic [31:0] br_link_o;
    logic        ctl_if_allow_in_i;
    logic [32:0] jbr_bus_o;

    int total = 0;
    int bad   = 0;

    jbr_gen #(.RegW(32)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .ctl_br_valid_i      (ctl_br_valid_i),
        .ctl_br_allow_in_o   (ctl_br_allow_in_o),
        .br_pc_i             (br_pc_i),
        .br_op_i             (br_op_i),
        .br_src1_i           (br_src1_i),
        .br_src2_i           (br_src2_i),
        .br_offs_i           (br_offs_i),
        .ctl_next_allow_in_i (ctl_next_allow_in_i),
        .ctl_br_over_o       (ctl_br_over_o),
        .br_link_we_o        (br_link_we_o),
        .br_link_o           (br_link_o),
        .ctl_if_allow_in_i   (ctl_if_allow_in_i),
        .jbr_bus_o           (jbr_bus_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [3:0] op,
                           input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] offs);
        ctl_br_valid_i = 1'b1;
        br_pc_i   = pc;
        br_op_i   = op;
        br_src1_i = s1;
        br_src2_i = s2;
        br_offs_i = offs;
    endtask

    initial begin
        rst_i = 1'b1;
        ctl_br_valid_i = 1'b0;
        br_pc_i = '0; br_op_i = '0; br_src1_i = '0; br_src2_i = '0; br_offs_i = '0;
        ctl_next_allow_in_i = 1'b1;
        ctl_if_allow_in_i   = 1'b1;

        // reset
        step(); step();
        chk("rst_bus",     64'(jbr_bus_o), 64'h0);
        chk("rst_over",    64'(ctl_br_over_o), 64'h0);
        chk("rst_link_we", 64'(br_link_we_o), 64'h0);
        chk("rst_link",    64'(br_link_o), 64'h0);
        chk("rst_allow",   64'(ctl_br_allow_in_o), 64'h1);
        rst_i = 1'b0;

        // BEQ taken
        present(32'h1C000000, 4'd1, 32'd5, 32'd5, 32'h40);
        step();
        ctl_br_valid_i = 1'b0;
        chk("beq_bus",     64'(jbr_bus_o), 64'h1_1C000040);
        chk("beq_over",    64'(ctl_br_over_o), 64'h1);
        chk("beq_link_we", 64'(br_link_we_o), 64'h0);
        chk("beq_link",    64'(br_link_o), 64'h1C000004);
        step();
        chk("beq_bus_off", 64'(jbr_bus_o), 64'h0);
        chk("beq_over_off",64'(ctl_br_over_o), 64'h0);
        present(32'h1C000040, 4'd0, 32'd0, 32'd0, 32'd0);
        step();
        ctl_br_valid_i = 1'b0;
        chk("tgt_hit_over", 64'(ctl_br_over_o), 64'h1);
        chk("tgt_hit_bus",  64'(jbr_bus_o), 64'h0);

        // BLTU not taken, then BLT taken with the same operands
        present(32'h1C000100, 4'd5, 32'hFFFFFFFF, 32'd1, 32'h20);
        step();
        chk("bltu_bus",  64'(jbr_bus_o), 64'h0);
        chk("bltu_over", 64'(ctl_br_over_o), 64'h1);
        present(32'h1C000104, 4'd3, 32'hFFFFFFFF, 32'd1, 32'h20);
        step();
        ctl_br_valid_i = 1'b0;
        chk("blt_bus",  64'(jbr_bus_o), 64'h1_1C000124);
        chk("blt_link", 64'(br_link_o), 64'h1C000108);
        step();
        present(32'h1C000124, 4'd0, 32'd0, 32'd0, 32'd0);
        step();
        ctl_br_valid_i = 1'b0;
        chk("blt_tgt_over", 64'(ctl_br_over_o), 64'h1);

        // JIRL held under a 3-cycle fetch stall
        ctl_if_allow_in_i = 1'b0;
        present(32'h1C000200, 4'd9, 32'h1C001000, 32'd0, 32'h8);
        step();
        ctl_br_valid_i = 1'b0;
        chk("jirl_bus",     64'(jbr_bus_o), 64'h1_1C001008);
        chk("jirl_link",    64'(br_link_o), 64'h1C000204);
        chk("jirl_link_we", 64'(br_link_we_o), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("jirl_hold%0d", i), 64'(jbr_bus_o), 64'h1_1C001008);
        end
        ctl_if_allow_in_i = 1'b1;
        step();
        chk("jirl_bus_off", 64'(jbr_bus_o), 64'h0);

        // B back to 0x1C000100 from the JIRL target, then squash
        present(32'h1C001008, 4'd7, 32'd0, 32'd0, 32'hFFFFF0F8);
        step();
        ctl_br_valid_i = 1'b0;
        chk("b_back_bus", 64'(jbr_bus_o), 64'h1_1C000100);
        step();
        chk("b_back_off", 64'(jbr_bus_o), 64'h0);
        present(32'h1C000004, 4'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("sq_drop0", 64'(ctl_br_over_o), 64'h0);
        present(32'h1C000008, 4'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("sq_drop1", 64'(ctl_br_over_o), 64'h0);
        present(32'h1C000100, 4'd7, 32'd0, 32'd0, 32'h10);
        step();
        chk("sq_hit_bus",  64'(jbr_bus_o), 64'h1_1C000110);
        chk("sq_hit_over", 64'(ctl_br_over_o), 64'h1);
        chk("sq_hit_link", 64'(br_link_o), 64'h1C000104);

        // in REDIRECT even an instruction at the target pc is dropped
        ctl_if_allow_in_i = 1'b0;
        present(32'h1C000110, 4'd7, 32'd0, 32'd0, 32'h10);
        step();
        ctl_br_valid_i = 1'b0;
        chk("redir_drop_over", 64'(ctl_br_over_o), 64'h0);
        chk("redir_drop_bus",  64'(jbr_bus_o), 64'h1_1C000110);

        // reset while the bus is active
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst_bus",  64'(jbr_bus_o), 64'h0);
        chk("midrst_over", 64'(ctl_br_over_o), 64'h0);
        present(32'h1C000300, 4'd2, 32'd1, 32'd2, 32'h8);
        step();
        ctl_br_valid_i = 1'b0;
        chk("post_rst_bus",  64'(jbr_bus_o), 64'h1_1C000308);
        chk("post_rst_over", 64'(ctl_br_over_o), 64'h1);

        // downstream stall: output held, allow_in drops, redirect still clears
        ctl_next_allow_in_i = 1'b0;
        ctl_if_allow_in_i   = 1'b1;
        step();
        chk("stall_over",  64'(ctl_br_over_o), 64'h1);
        chk("stall_allow", 64'(ctl_br_allow_in_o), 64'h0);
        chk("stall_bus",   64'(jbr_bus_o), 64'h0);
        ctl_next_allow_in_i = 1'b1;
        step();
        chk("unstall_over", 64'(ctl_br_over_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
